move_input_ctrl: RTL and testbench
==================================

# move_input_ctrl

Sequences the 4x4 matrix keyboard into complete Go moves for the game core. It enables the keyboard only while the core is waiting for a move, and drains scanned keys over the keyboard's valid/ready handshake. It assembles column and row coordinates, supports pass, backspace, cancel and confirm, and applies an optional inactivity timeout. It issues exactly one move per request to the core over a second valid/ready handshake, and sits between the keyboard and the game state machine.

## Interface
- BOARD_SIZE, default 9: legal coordinate range 0..BOARD_SIZE-1; allowed 2..12.
- TIMEOUT_CYCLES, default 0: clk cycles of inactivity before auto-pass; 0 disables the timeout.
- clk  in  1  system clock (same clk as keyboard handshake side)
- rst_n  in  1  reset, synchronous, active-low
- input_req  in  1  core is waiting for a move; level
- kb_en  out  1  keyboard scan enable
- key_valid  in  1  keyboard has a decoded key
- key_index  in  4  key code, valid with key_valid
- key_ready  out  1  controller accepts key
- move_valid  out  1  move payload valid
- move_ready  in  1  core accepts move
- move_x  out  4  column, 0-based
- move_y  out  4  row, 0-based
- move_pass  out  1  move is a pass; move_x/move_y are 0 when set
- stage  out  2  0 idle, 1 entering x, 2 entering y, 3 confirm/issue (display)
- key_err  out  1  one-cycle pulse: rejected key

## Operation
- Key codes: 0x0-0xB are digits; 0xC is PASS; 0xD is BACK; 0xE is CANCEL; 0xF is CONFIRM.
- A key is transferred on key_valid && key_ready.
- key_ready=1 in every state except ISSUE.
- Keys transferred in IDLE are discarded silently; no key_err.
- kb_en=1 in GET_X, GET_Y and CONFIRM; kb_en=0 in IDLE and ISSUE.
- States:
  - IDLE, stage 0: on input_req, clear x/y/pass and go to GET_X.
  - GET_X, stage 1:
    - digit < BOARD_SIZE: store in x, go to GET_Y.
    - PASS: set pass, go to CONFIRM.
    - BACK or CANCEL: stay.
    - digit >= BOARD_SIZE or CONFIRM: key_err.
  - GET_Y, stage 2:
    - digit < BOARD_SIZE: store in y, go to CONFIRM.
    - BACK: clear x, go to GET_X.
    - CANCEL: clear x/y, go to GET_X.
    - PASS, CONFIRM or digit >= BOARD_SIZE: key_err.
  - CONFIRM, stage 3:
    - CONFIRM: go to ISSUE.
    - BACK: if pass, clear pass and go to GET_X; else clear y and go to GET_Y.
    - CANCEL: clear all, go to GET_X.
    - Digit or PASS: key_err.
  - ISSUE, stage 3: move_valid=1 and payload held stable. On move_ready, go to IDLE.
- Abort: input_req low in GET_X, GET_Y or CONFIRM forces IDLE next cycle. The key transferred in that same cycle is discarded.
- ISSUE ignores input_req and waits for the handshake.
- Timeout counter:
  - Runs only in GET_X, GET_Y and CONFIRM.
  - Clears on every transferred key and on entry to GET_X from IDLE.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - When it reaches TIMEOUT_CYCLES-1 with no key transfer that cycle, force pass=1, x=y=0 and go to ISSUE.
  - Abort has priority over timeout. A key transfer has priority over timeout in the same cycle.

## Timing
- Reset values: state IDLE; kb_en=0, key_ready=0, move_valid=0, move_x=0, move_y=0, move_pass=0, stage=0, key_err=0; counter 0.
- All outputs are registered or decoded from registered state.
- key_ready goes to 1 the first cycle after reset deasserts.
- input_req sampled high in IDLE at edge N: kb_en=1 and stage=1 from edge N+1.
- Key transferred at edge N: state, x/y and stage update at edge N+1; key_err pulses during the cycle after N.
- CONFIRM key transferred at edge N: move_valid=1 from edge N+1.
- move_ready sampled at edge M: move_valid=0 from edge M+1. This is the minimum 1-cycle ISSUE.
- Timeout: auto-pass move_valid rises exactly TIMEOUT_CYCLES cycles after the last counter clear.
- Reset mid-ISSUE drops move_valid with no handshake. The core must not count that move.

## Structure
- Key code constants (KEY_PASS, KEY_BACK, KEY_CANCEL, KEY_CONFIRM, digit limit) go in the shared go-keys constants package/include; the game core and display also use them.
- State encoding stays local to this block.
- One sub-module is natural: move_timeout_timer. It takes inputs clear and run, produces a one-cycle expired output, and is parameterised by TIMEOUT_CYCLES. It is tied off when TIMEOUT_CYCLES=0.

## Test plan
- Basic move: input_req=1; keys 0x3, 0x5, 0xF; move_ready=1 → one move_valid cycle with x=3, y=5, pass=0; kb_en=0 after the handshake.
- Edits: keys 0x2, 0xD, 0x4, 0x7, 0xE, 0x1, 0x8, 0xD, 0x6, 0xF → move x=1, y=6; stage follows 1,2,1,2,3,1,2,3,2,3.
- Errors with BOARD_SIZE=9: key 0x9 in GET_X, then 0xF in GET_X, then 0xC in GET_Y → three key_err pulses; state unchanged each time; final 0x0, 0x0, 0xF gives move (0,0).
- Backpressure and pass: key 0xC, then 0xF, with move_ready=0 for 5 cycles → move_valid held with pass=1, x=y=0; no key_ready during ISSUE; a single transfer when move_ready=1.
- Timeout with TIMEOUT_CYCLES=20: key 0x4, then idle → pass move_valid 20 cycles after the key transfer. A key at cycle 19 instead restarts the count.
- Abort/reset: drop input_req in GET_Y → IDLE and kb_en=0 next cycle, no move. Assert rst_n=0 during ISSUE → all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/move_input_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// move_input_ctrl_pkg
// Go-keys constants shared by the move input controller, the game core and
// the display: the 4x4 keypad codes and a helper that sorts a key code into
// the classes the move entry logic cares about.
// No ports (package).
// -----------------------------------------------------------------------------
package move_input_ctrl_pkg;

  // Codes below KEY_DIGIT_LIMIT are digits 0..11.
  localparam logic [3:0] KEY_DIGIT_LIMIT = 4'hC;
  localparam logic [3:0] KEY_PASS        = 4'hC;
  localparam logic [3:0] KEY_BACK        = 4'hD;
  localparam logic [3:0] KEY_CANCEL      = 4'hE;
  localparam logic [3:0] KEY_CONFIRM     = 4'hF;

  // KC_COORD is a digit that is a legal coordinate on the current board;
  // KC_BAD_DIGIT is a digit at or beyond the board edge.
  typedef enum logic [2:0] {
    KC_COORD     = 3'd0,
    KC_BAD_DIGIT = 3'd1,
    KC_PASS      = 3'd2,
    KC_BACK      = 3'd3,
    KC_CANCEL    = 3'd4,
    KC_CONFIRM   = 3'd5
  } key_class_e;

  function automatic key_class_e classify_key(input logic [3:0] code,
                                              input int unsigned board_size);
    key_class_e kc;
    if (code < KEY_DIGIT_LIMIT) begin
      kc = (32'(code) < board_size) ? KC_COORD : KC_BAD_DIGIT;
    end else begin
      unique case (code)
        KEY_PASS:   kc = KC_PASS;
        KEY_BACK:   kc = KC_BACK;
        KEY_CANCEL: kc = KC_CANCEL;
        default:    kc = KC_CONFIRM;
      endcase
    end
    return kc;
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// move_input_ctrl_if
// Bundles the move controller's two handshakes plus the core's request level
// and the keyboard enable.
//   input_req            core -> ctrl  core is waiting for a move (level)
//   kb_en                ctrl -> kbd   keyboard scan enable
//   key_valid/key_index  kbd  -> ctrl  decoded key offer
//   key_ready            ctrl -> kbd   controller accepts the key
//   move_valid/move_x/move_y/move_pass  ctrl -> core  move payload
//   move_ready           core -> ctrl  core accepts the move
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. Once valid is raised the payload is held stable until that
// transfer; ready may be asserted independently of valid.
//
// Modports: master = controller side, slave = keyboard/core side.
// -----------------------------------------------------------------------------
interface move_input_ctrl_if;
  logic       input_req;
  logic       kb_en;
  logic       key_valid;
  logic [3:0] key_index;
  logic       key_ready;
  logic       move_valid;
  logic       move_ready;
  logic [3:0] move_x;
  logic [3:0] move_y;
  logic       move_pass;

  modport master (
    input  input_req, key_valid, key_index, move_ready,
    output kb_en, key_ready, move_valid, move_x, move_y, move_pass
  );

  modport slave (
    output input_req, key_valid, key_index, move_ready,
    input  kb_en, key_ready, move_valid, move_x, move_y, move_pass
  );
endinterface

// File: rtl/move_timeout_timer.sv
// -----------------------------------------------------------------------------
// move_timeout_timer
// Inactivity counter for move entry. Counts clk cycles while run_i is high;
// clear_i forces the count back to zero and wins over run_i. expired_o is a
// one-cycle pulse in the cycle the count sits at TIMEOUT_CYCLES-1 while
// running and not being cleared, so the consumer acts on the edge that ends
// the TIMEOUT_CYCLES-th cycle after the last clear.
// Only instantiated with TIMEOUT_CYCLES >= 1.
//   clk, rst_n  clock, synchronous active-low reset
//   clear_i     restart the count
//   run_i       count this cycle
//   expired_o   timeout pulse
// -----------------------------------------------------------------------------
module move_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last   = run_i && (cnt_q == LAST);
  assign expired_o = at_last && !clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      // Wrap on expiry; the controller leaves the running states anyway.
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// -----------------------------------------------------------------------------
// move_input_ctrl
// Turns keypad presses into one complete Go move per core request. The
// keyboard is enabled only while a move is being entered; keys are drained
// over the key handshake, column then row are collected, with pass, back,
// cancel and confirm editing, and an optional inactivity auto-pass. The
// finished move is offered to the core over the move handshake.
//   clk, rst_n    clock, synchronous active-low reset
//   ctrl_if       move_input_ctrl_if.master (key + move handshakes, input_req,
//                 kb_en)
//   stage_o       0 idle, 1 entering x, 2 entering y, 3 confirm/issue
//   key_err_o     one-cycle pulse for a rejected key
//   dbg_state_o   raw FSM state for debug/checkers
// Parameters: BOARD_SIZE (2..12) legal coordinates 0..BOARD_SIZE-1;
//             TIMEOUT_CYCLES inactivity cycles before auto-pass, 0 = off.
// -----------------------------------------------------------------------------
module move_input_ctrl
  import move_input_ctrl_pkg::*;
#(
  parameter int unsigned BOARD_SIZE     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  move_input_ctrl_if.master   ctrl_if,
  output logic [1:0]          stage_o,
  output logic                key_err_o,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_X   = 3'd1,
    S_GET_Y   = 3'd2,
    S_CONFIRM = 3'd3,
    S_ISSUE   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic       pass_q, pass_d;
  logic       key_err_q, key_err_d;
  logic       key_ready_q;

  logic       key_xfer;
  logic       scanning;
  logic       abort;
  logic       tmo_expired;
  logic       tmo_clear;
  key_class_e kc;

  assign key_xfer = ctrl_if.key_valid && key_ready_q;
  assign scanning = (state_q == S_GET_X) || (state_q == S_GET_Y) ||
                    (state_q == S_CONFIRM);
  assign abort    = scanning && !ctrl_if.input_req;
  assign kc       = classify_key(ctrl_if.key_index, BOARD_SIZE);

  // Sitting in IDLE keeps the count at zero, so entering GET_X starts fresh.
  assign tmo_clear = key_xfer || (state_q == S_IDLE);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      logic unused_tmo;
      assign unused_tmo  = tmo_clear ^ scanning;
      assign tmo_expired = 1'b0;
    end else begin : g_timeout
      move_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmo_clear),
        .run_i     (scanning),
        .expired_o (tmo_expired)
      );
    end
  endgenerate

  // Next-state and datapath. Priority in the entry states:
  // abort, then a transferred key, then timeout.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pass_d    = pass_q;
    key_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Keys taken here are dropped on purpose (no error).
        if (ctrl_if.input_req) begin
          x_d     = '0;
          y_d     = '0;
          pass_d  = 1'b0;
          state_d = S_GET_X;
        end
      end

      S_GET_X: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (key_xfer) begin
          unique case (kc)
            KC_COORD: begin
              x_d     = ctrl_if.key_index;
              state_d = S_GET_Y;
            end
            KC_PASS: begin
              pass_d  = 1'b1;
              state_d = S_CONFIRM;
            end
            KC_BACK, KC_CANCEL: ;
            default: key_err_d = 1'b1;
          endcase
        end else if (tmo_expired) begin
          pass_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = S_ISSUE;
        end
      end

      S_GET_Y: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (key_xfer) begin
          unique case (kc)
            KC_COORD: begin
              y_d     = ctrl_if.key_index;
              state_d = S_CONFIRM;
            end
            KC_BACK: begin
              x_d     = '0;
              state_d = S_GET_X;
            end
            KC_CANCEL: begin
              x_d     = '0;
              y_d     = '0;
              state_d = S_GET_X;
            end
            default: key_err_d = 1'b1;
          endcase
        end else if (tmo_expired) begin
          pass_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = S_ISSUE;
        end
      end

      S_CONFIRM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (key_xfer) begin
          unique case (kc)
            KC_CONFIRM: state_d = S_ISSUE;
            KC_BACK: begin
              // Back undoes whichever entry got us here: the pass or the row.
              if (pass_q) begin
                pass_d  = 1'b0;
                state_d = S_GET_X;
              end else begin
                y_d     = '0;
                state_d = S_GET_Y;
              end
            end
            KC_CANCEL: begin
              x_d     = '0;
              y_d     = '0;
              pass_d  = 1'b0;
              state_d = S_GET_X;
            end
            default: key_err_d = 1'b1;
          endcase
        end else if (tmo_expired) begin
          pass_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Payload frozen; input_req is ignored until the core takes the move.
        if (ctrl_if.move_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pass_q      <= 1'b0;
      key_err_q   <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pass_q      <= pass_d;
      key_err_q   <= key_err_d;
      // Registered from the next state so it is low during reset and in
      // ISSUE, and rises the first cycle after reset is released.
      key_ready_q <= (state_d != S_ISSUE);
    end
  end

  assign ctrl_if.kb_en      = scanning;
  assign ctrl_if.key_ready  = key_ready_q;
  assign ctrl_if.move_valid = (state_q == S_ISSUE);
  assign ctrl_if.move_x     = x_q;
  assign ctrl_if.move_y     = y_q;
  assign ctrl_if.move_pass  = pass_q;

  assign stage_o     = (state_q == S_ISSUE) ? 2'd3 : state_q[1:0];
  assign key_err_o   = key_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_move_input_ctrl
// Drives move_input_ctrl (BOARD_SIZE=9, TIMEOUT_CYCLES=20) with directed move
// sequences and a randomized stretch. A queue-based reference model tracks
// the entered coordinates as a list of digits plus a pass flag; every cycle's
// outputs are compared against it, and completed moves flow through an
// expected-move queue checked at each move handshake.
// -----------------------------------------------------------------------------
module tb_move_input_ctrl;
  import move_input_ctrl_pkg::*;

  localparam int BOARD = 9;
  localparam int TMO   = 20;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] stage;
  logic       key_err;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  move_input_ctrl_if bus ();

  move_input_ctrl #(
    .BOARD_SIZE     (BOARD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_if     (bus),
    .stage_o     (stage),
    .key_err_o   (key_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         tests = 0;
  int         fails = 0;
  int         hs_cnt = 0;
  logic [8:0] last_move = '0;   // {pass, x, y} seen at the last handshake
  logic [8:0] exp_q[$];

  // ---------------- reference model ----------------
  bit         m_active = 0;   // a move request is being served
  bit         m_issue  = 0;   // move offered to the core
  bit         m_pass   = 0;
  bit         m_kr     = 0;   // predicted key_ready
  bit         m_err    = 0;
  int         m_tcnt   = 0;   // cycles since last inactivity restart
  logic [3:0] ent[$];         // entered coordinates, x first

  function automatic logic [3:0] mx();
    return (ent.size() > 0) ? ent[0] : 4'd0;
  endfunction

  function automatic logic [3:0] my();
    return (ent.size() > 1) ? ent[1] : 4'd0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         xfer;
    logic [3:0] k;
    xfer  = bus.key_valid && m_kr;
    k     = bus.key_index;
    m_err = 0;
    if (!rst_n) begin
      m_active = 0; m_issue = 0; m_pass = 0; m_kr = 0; m_tcnt = 0;
      ent.delete();
      exp_q.delete();
      return;
    end
    if (!m_active) begin
      if (bus.input_req) begin
        m_active = 1; m_pass = 0; m_tcnt = 0;
        ent.delete();
      end
    end else if (m_issue) begin
      if (bus.move_ready) begin
        m_active = 0; m_issue = 0;
      end
    end else if (!bus.input_req) begin
      m_active = 0;
    end else if (xfer) begin
      m_tcnt = 0;
      if (m_pass || ent.size() == 2) begin
        if (k == KEY_CONFIRM) begin
          m_issue = 1;
          exp_q.push_back({m_pass, mx(), my()});
        end else if (k == KEY_BACK) begin
          if (m_pass) m_pass = 0;
          else void'(ent.pop_back());
        end else if (k == KEY_CANCEL) begin
          m_pass = 0;
          ent.delete();
        end else begin
          m_err = 1;
        end
      end else if (32'(k) < BOARD) begin
        ent.push_back(k);
      end else if (k == KEY_PASS && ent.size() == 0) begin
        m_pass = 1;
      end else if (k == KEY_BACK || k == KEY_CANCEL) begin
        // Nothing to undo before x; with x entered both drop it.
        ent.delete();
      end else begin
        m_err = 1;
      end
    end else begin
      m_tcnt++;
      if (m_tcnt == TMO) begin
        m_pass = 1;
        ent.delete();
        m_issue = 1;
        exp_q.push_back({m_pass, mx(), my()});
      end
    end
    m_kr = !m_issue;
  endtask

  task automatic check_outputs();
    int exp_stage;
    if (!m_active) exp_stage = 0;
    else if (m_issue || m_pass || ent.size() == 2) exp_stage = 3;
    else exp_stage = ent.size() + 1;
    check_eq("kb_en",      32'(bus.kb_en),      32'(m_active && !m_issue));
    check_eq("key_ready",  32'(bus.key_ready),  32'(m_kr));
    check_eq("move_valid", 32'(bus.move_valid), 32'(m_issue));
    check_eq("move_x",     32'(bus.move_x),     32'(mx()));
    check_eq("move_y",     32'(bus.move_y),     32'(my()));
    check_eq("move_pass",  32'(bus.move_pass),  32'(m_pass));
    check_eq("stage",      32'(stage),          32'(exp_stage));
    check_eq("key_err",    32'(key_err),        32'(m_err));
    check_eq("dbg_idle",   32'(dbg_state == 3'd0), 32'(!m_active));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after an edge; outputs are checked there too.
  task automatic cycle(input bit req, input bit kv, input logic [3:0] ki, input bit mr);
    logic [8:0] seen;
    bus.input_req  = req;
    bus.key_valid  = kv;
    bus.key_index  = ki;
    bus.move_ready = mr;
    if (rst_n && bus.move_valid && mr) begin
      seen = {bus.move_pass, bus.move_x, bus.move_y};
      check_eq("hs_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) check_eq("hs_move", 32'(seen), 32'(exp_q.pop_front()));
      last_move = seen;
      hs_cnt++;
    end
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic key(input logic [3:0] k);
    cycle(1'b1, 1'b1, k, 1'b0);
  endtask

  task automatic begin_move();
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic handshake();
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  // Idle with input_req high until move_valid; returns cycles waited.
  task automatic wait_timeout(output int n);
    n = 0;
    while (!bus.move_valid && n < 40) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] edit_keys[10]   = '{4'h2, 4'hD, 4'h4, 4'h7, 4'hE, 4'h1, 4'h8, 4'hD, 4'h6, 4'hF};
  int         edit_stages[10] = '{1, 2, 1, 2, 3, 1, 2, 3, 2, 3};

  initial begin
    int n;
    int base;
    bit req_r;
    bus.input_req  = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_index  = 4'h0;
    bus.move_ready = 1'b0;

    // Reset state, then release
    repeat (3) cycle(1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("rst_key_ready", 32'(bus.key_ready), 32'(0));
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("ready_after_rst", 32'(bus.key_ready), 32'(1));

    // Basic move 3,5 confirm
    begin_move();
    check_eq("basic_kb_en_on", 32'(bus.kb_en), 32'(1));
    key(4'h3); key(4'h5); key(4'hF);
    check_eq("basic_valid", 32'(bus.move_valid), 32'(1));
    base = hs_cnt;
    handshake();
    check_eq("basic_hs_count", 32'(hs_cnt), 32'(base + 1));
    check_eq("basic_move", 32'(last_move), 32'(9'h035));
    check_eq("basic_kb_en_off", 32'(bus.kb_en), 32'(0));
    check_eq("basic_valid_drop", 32'(bus.move_valid), 32'(0));

    // Edits: stage seen before each key
    begin_move();
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("edit_stage%0d", i), 32'(stage), 32'(edit_stages[i]));
      key(edit_keys[i]);
    end
    handshake();
    check_eq("edit_move", 32'(last_move), 32'(9'h016));

    // Rejected keys on a 9x9 board
    begin_move();
    key(4'h9);
    check_eq("err_bad_digit", 32'(key_err), 32'(1));
    check_eq("err_bad_digit_stage", 32'(stage), 32'(1));
    key(4'hF);
    check_eq("err_early_confirm", 32'(key_err), 32'(1));
    key(4'h0);
    check_eq("err_pulse_clears", 32'(key_err), 32'(0));
    key(4'hC);
    check_eq("err_pass_in_y", 32'(key_err), 32'(1));
    check_eq("err_pass_in_y_stage", 32'(stage), 32'(2));
    key(4'h0); key(4'hF);
    handshake();
    check_eq("err_move", 32'(last_move), 32'(9'h000));

    // Pass with backpressure; keys offered during ISSUE must not transfer
    begin_move();
    key(4'hC); key(4'hF);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid_held", 32'(bus.move_valid), 32'(1));
      check_eq("bp_no_ready", 32'(bus.key_ready), 32'(0));
      cycle(1'b1, 1'b1, 4'h3, 1'b0);
    end
    base = hs_cnt;
    handshake();
    check_eq("bp_single_hs", 32'(hs_cnt), 32'(base + 1));
    check_eq("bp_move", 32'(last_move), 32'(9'h100));
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("bp_hs_once", 32'(hs_cnt), 32'(base + 1));

    // Timeout: auto-pass TMO cycles after the last key
    begin_move();
    key(4'h4);
    wait_timeout(n);
    check_eq("tmo_latency", 32'(n), 32'(TMO));
    handshake();
    check_eq("tmo_move", 32'(last_move), 32'(9'h100));

    // A key one cycle before expiry restarts the count
    begin_move();
    key(4'h4);
    repeat (TMO - 2) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    key(4'h5);
    wait_timeout(n);
    check_eq("tmo_restart_latency", 32'(n), 32'(TMO));
    handshake();
    check_eq("tmo_restart_move", 32'(last_move), 32'(9'h100));

    // Abort in GET_Y; the key in the abort cycle is dropped silently
    begin_move();
    key(4'h2);
    base = hs_cnt;
    cycle(1'b0, 1'b1, 4'h7, 1'b0);
    check_eq("abort_stage", 32'(stage), 32'(0));
    check_eq("abort_kb_en", 32'(bus.kb_en), 32'(0));
    check_eq("abort_no_err", 32'(key_err), 32'(0));
    repeat (3) cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("abort_no_move", 32'(hs_cnt), 32'(base));

    // Reset while the move is being offered
    begin_move();
    key(4'h1); key(4'h2); key(4'hF);
    check_eq("rstiss_valid", 32'(bus.move_valid), 32'(1));
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check_eq("rstiss_valid_drop", 32'(bus.move_valid), 32'(0));
    check_eq("rstiss_ready", 32'(bus.key_ready), 32'(0));
    check_eq("rstiss_x", 32'(bus.move_x), 32'(0));
    check_eq("rstiss_stage", 32'(stage), 32'(0));
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 4'h0, 1'b0);

    // Randomized stretch
    req_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) req_r = !req_r;
      if ($urandom_range(0, 249) == 0) begin
        for (int j = 0; j < 25; j++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
      end
      cycle(req_r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
    end

    // Drain any offered move
    repeat (5) cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
